glip_uart_egress_arbiter: RTL and testbench
===========================================

# glip_uart_egress_arbiter

Arbiter and framer for the single UART transmit byte channel of the UART backend. It shares the transmitter between three requesters: control acknowledges, receive-credit messages, and payload bytes from the logic-to-UART FIFO. It serialises each into escape-framed byte sequences and drives the transmitter's enable/done handshake. It sits in the `clk_io` domain between the egress FIFO read side, the flow-control logic and `glip_uart_transmit`.

## Interface
- `ESCAPE`, 8'hfe: escape byte value. Must be >= 8'hd0 so that it never collides with a command byte.
- `clk`  in  1  single clock for all logic (`clk_io` at toplevel).
- `rst`  in  1  reset; asynchronous, active-high.
- `hold`  in  1  when 1, no new message starts; a message already in progress completes.
- `ack_req`  in  1  control-acknowledge request (level).
- `ack_code`  in  4  acknowledge code.
- `ack_grant`  out  1  one-cycle pulse in the cycle the ack request is accepted.
- `credit_req`  in  1  credit-message request (level).
- `credit_value`  in  14  credit to announce.
- `credit_grant`  out  1  one-cycle pulse in the cycle the credit request is accepted.
- `egress_in_data`  in  8  payload byte; first-word-fall-through FIFO head.
- `egress_in_valid`  in  1  payload byte available.
- `egress_in_ready`  out  1  one-cycle read pulse; the byte is consumed.
- `tx_data`  out  8  byte to transmitter.
- `tx_enable`  out  1  transmit request.
- `tx_done`  in  1  one-cycle pulse from the transmitter when the byte is finished.
- `busy`  out  1  1 when the FSM is not in IDLE.

## Operation
Message formats (bytes in order):
- Ack: `ESCAPE`, {4'b1100, ack_code}.
- Credit: `ESCAPE`, {2'b10, credit_value[13:8]}, credit_value[7:0].
- Data byte b != `ESCAPE`: b.
- Data byte == `ESCAPE`: `ESCAPE`, `ESCAPE`.

Arbitration:
- Fixed priority: ack > credit > data.
- Evaluated only in IDLE with hold=0.
- A message is never preempted or interleaved; an escaped data pair is atomic.

Acceptance:
- In IDLE with hold=0, the winning requester is accepted in that cycle. Its grant or `egress_in_ready` is asserted combinationally in that cycle, and its payload is captured into a 3-byte message buffer with a 2-bit length (1..3) on that clock edge.
- `egress_in_ready` is only ever asserted together with `egress_in_valid`.
- Requests held across a message are served afterwards. Grant pulses are never repeated for a single acceptance; a requester holding req high after its grant is a new request.

FSM:
- IDLE: no message. On acceptance -> BYTE with index=0.
- BYTE: tx_enable=1, tx_data=buf[index]. On tx_done: if index==len-1 -> IDLE, else -> GAP with index+1.
- GAP: tx_enable=0 for exactly one cycle -> BYTE.

Other rules:
- tx_done outside BYTE is ignored.
- ack_code and credit_value are sampled only at acceptance; later changes do not affect the message in flight.

## Timing
- Reset values (asynchronous, immediate): state IDLE, tx_enable=0, tx_data=8'h00, ack_grant=0, credit_grant=0, egress_in_ready=0, busy=0, buffer and index cleared.
- Reset mid-message: the in-flight message is dropped with no resume, and tx_enable falls immediately.
- Latency: acceptance in cycle N -> tx_enable=1 with the first byte in cycle N+1.
- tx_data is stable for the whole time tx_enable=1.
- After the tx_done cycle, tx_enable is 0 for at least one cycle:
  - GAP between bytes of one message.
  - IDLE between messages. The earliest next acceptance is the cycle after done, so the next enable comes 2 cycles after done.
- tx_done in the same cycle as reset assertion: reset wins.
- hold rising during BYTE/GAP has no effect until IDLE.
- Simultaneous requests: exactly one grant per acceptance cycle.

## Test plan
- Single data 0x41, idle transmitter: ready pulses once; tx_enable rises next cycle with tx_data=0x41; after tx_done -> IDLE, busy=0.
- Data 0xFE: one ready pulse; bytes 0xFE, GAP, 0xFE; exactly one GAP cycle between them.
- credit_value=14'h1234: credit_grant pulse; bytes 0xFE, 0x92, 0x34; changing credit_value mid-message does not alter the bytes.
- ack_req (code 3), credit_req (0x0005) and valid data 0x10 all asserted in the same cycle: sequence 0xFE 0xC3 | 0xFE 0x80 0x05 | 0x10; grants in that order, one per message.
- hold=1 with pending data: no ready and tx_enable stays 0; asserting hold during a credit message lets all 3 bytes complete; releasing hold starts the data byte the next cycle.
- Reset asserted while the 2nd byte of a credit message is enabled: tx_enable=0 immediately, busy=0; after release, a fresh request transmits cleanly from byte 0.

Source files
------------

// File: rtl/glip_uart_egress_arbiter_if.sv
// Purpose: bundle of request, grant, FIFO and transmitter handshake signals
//          around the UART egress arbiter.
// Ports (master = arbiter side):
//   hold, ack_req, ack_code, credit_req, credit_value,
//   egress_in_data, egress_in_valid, tx_done            -> into the arbiter
//   ack_grant, credit_grant, egress_in_ready,
//   tx_data, tx_enable, busy                            <- out of the arbiter
interface glip_uart_egress_arbiter_if;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned CREDIT_W = 14;
    localparam int unsigned BYTE_W   = 8;

    logic                hold;
    logic                ack_req;
    logic [CODE_W-1:0]   ack_code;
    logic                ack_grant;
    logic                credit_req;
    logic [CREDIT_W-1:0] credit_value;
    logic                credit_grant;
    logic [BYTE_W-1:0]   egress_in_data;
    logic                egress_in_valid;
    logic                egress_in_ready;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_enable;
    logic                tx_done;
    logic                busy;

    modport master (
        input  hold, ack_req, ack_code, credit_req, credit_value,
               egress_in_data, egress_in_valid, tx_done,
        output ack_grant, credit_grant, egress_in_ready,
               tx_data, tx_enable, busy
    );

    modport slave (
        output hold, ack_req, ack_code, credit_req, credit_value,
               egress_in_data, egress_in_valid, tx_done,
        input  ack_grant, credit_grant, egress_in_ready,
               tx_data, tx_enable, busy
    );
endinterface

// File: rtl/glip_uart_egress_arbiter.sv
// Purpose: shares the UART transmit byte channel between control acks,
//          credit messages and payload bytes; frames each into an
//          escape-coded byte sequence and drives the tx enable/done handshake.
// Ports:
//   clk  - clk_io domain clock
//   rst  - asynchronous active-high reset
//   arb  - master side of glip_uart_egress_arbiter_if (requests, grants,
//          FIFO head, transmitter handshake, busy)
module glip_uart_egress_arbiter #(
    parameter logic [7:0] ESCAPE = 8'hfe
) (
    input  logic                          clk,
    input  logic                          rst,
    glip_uart_egress_arbiter_if.master    arb
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BYTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        len_q, len_d;
    logic [2:0][BYTE_W-1:0]  msg_q, msg_d;
    logic [BYTE_W-1:0]       tx_data_q, tx_data_d;
    logic                    tx_enable_q, tx_enable_d;
    logic                    busy_q, busy_d;
    logic                    ack_grant_c, credit_grant_c, ready_c;
    logic                    accept_c;

    // State and message buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            msg_q       <= '0;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            msg_q       <= msg_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            busy_q      <= busy_d;
        end
    end

    // Arbitration, framing and next-state logic
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        msg_d          = msg_q;
        tx_data_d      = tx_data_q;
        tx_enable_d    = tx_enable_q;
        ack_grant_c    = 1'b0;
        credit_grant_c = 1'b0;
        ready_c        = 1'b0;
        accept_c       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!arb.hold) begin
                    // Fixed priority: ack > credit > data
                    if (arb.ack_req) begin
                        ack_grant_c = 1'b1;
                        accept_c    = 1'b1;
                        msg_d       = {8'h00, {4'b1100, arb.ack_code}, ESCAPE};
                        len_d       = 2'd2;
                    end else if (arb.credit_req) begin
                        credit_grant_c = 1'b1;
                        accept_c       = 1'b1;
                        msg_d          = {arb.credit_value[7:0],
                                          {2'b10, arb.credit_value[13:8]},
                                          ESCAPE};
                        len_d          = 2'd3;
                    end else if (arb.egress_in_valid) begin
                        ready_c  = 1'b1;
                        accept_c = 1'b1;
                        // A literal escape byte is doubled so the receiver
                        // never mistakes it for a command prefix.
                        if (arb.egress_in_data == ESCAPE) begin
                            msg_d = {8'h00, ESCAPE, ESCAPE};
                            len_d = 2'd2;
                        end else begin
                            msg_d = {8'h00, 8'h00, arb.egress_in_data};
                            len_d = 2'd1;
                        end
                    end
                end
                if (accept_c) begin
                    state_d     = ST_BYTE;
                    idx_d       = '0;
                    tx_enable_d = 1'b1;
                    tx_data_d   = msg_d[0];
                end
            end
            ST_BYTE: begin
                if (arb.tx_done) begin
                    tx_enable_d = 1'b0;
                    if (idx_q == IDX_W'(len_q - 2'd1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GAP;
                        idx_d   = IDX_W'(idx_q + 2'd1);
                    end
                end
            end
            ST_GAP: begin
                state_d     = ST_BYTE;
                tx_enable_d = 1'b1;
                tx_data_d   = msg_q[idx_q];
            end
            default: begin
                state_d     = ST_IDLE;
                tx_enable_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign arb.ack_grant       = ack_grant_c;
    assign arb.credit_grant    = credit_grant_c;
    assign arb.egress_in_ready = ready_c;
    assign arb.tx_data         = tx_data_q;
    assign arb.tx_enable       = tx_enable_q;
    assign arb.busy            = busy_q;
endmodule

// File: tb/tb_glip_uart_egress_arbiter.sv
// Directed bench for glip_uart_egress_arbiter: the bench plays the egress
// FIFO, the request sources and the UART transmitter.
module tb_glip_uart_egress_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    glip_uart_egress_arbiter_if tb_if ();

    glip_uart_egress_arbiter #(.ESCAPE(8'hfe)) dut (
        .clk (clk),
        .rst (rst),
        .arb (tb_if.master)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Grant observer: counts pulses and records grant order
    int n_ack    = 0;
    int n_cred   = 0;
    int n_rdy    = 0;
    int n_multi  = 0;
    int n_badrdy = 0;
    int order_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (tb_if.ack_grant === 1'b1) begin
                n_ack++;
                order_q.push_back(1);
            end
            if (tb_if.credit_grant === 1'b1) begin
                n_cred++;
                order_q.push_back(2);
            end
            if (tb_if.egress_in_ready === 1'b1) begin
                n_rdy++;
                order_q.push_back(3);
                if (tb_if.egress_in_valid !== 1'b1) n_badrdy++;
            end
            if ((int'(tb_if.ack_grant) + int'(tb_if.credit_grant)
                 + int'(tb_if.egress_in_ready)) > 1) n_multi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for tx_enable, checks the byte (held for dly extra cycles),
    // then completes it with a one-cycle tx_done. Requesters drop their
    // request on the edge after being granted.
    task automatic wait_byte(input logic [7:0] b, input string tag, input int dly, output int gap);
        bit found;
        bit drop_a, drop_c, drop_d;
        found = 1'b0;
        gap   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tb_if.tx_enable === 1'b1) begin
                found = 1'b1;
                break;
            end
            gap++;
            drop_a = tb_if.ack_grant;
            drop_c = tb_if.credit_grant;
            drop_d = tb_if.egress_in_ready;
            @(posedge clk);
            #1;
            if (drop_a) tb_if.ack_req = 1'b0;
            if (drop_c) tb_if.credit_req = 1'b0;
            if (drop_d) tb_if.egress_in_valid = 1'b0;
        end
        check({tag, "_en"}, 32'(found), 32'd1);
        if (found) begin
            check({tag, "_data"}, 32'(tb_if.tx_data), 32'(b));
            check({tag, "_busy"}, 32'(tb_if.busy), 32'd1);
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                check({tag, "_hold_en"}, 32'(tb_if.tx_enable), 32'd1);
                check({tag, "_hold_data"}, 32'(tb_if.tx_data), 32'(b));
            end
            tb_if.tx_done = 1'b1;
            @(posedge clk);
            #1;
            tb_if.tx_done = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_idle_en"}, 32'(tb_if.tx_enable), 32'd0);
        check({tag, "_idle_busy"}, 32'(tb_if.busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int base_a, base_c, base_r, base_q;

        rst                   = 1'b1;
        tb_if.hold            = 1'b0;
        tb_if.ack_req         = 1'b0;
        tb_if.ack_code        = 4'h0;
        tb_if.credit_req      = 1'b0;
        tb_if.credit_value    = 14'h0;
        tb_if.egress_in_data  = 8'h00;
        tb_if.egress_in_valid = 1'b0;
        tb_if.tx_done         = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_en",     32'(tb_if.tx_enable),       32'd0);
        check("rst_data",   32'(tb_if.tx_data),         32'h00);
        check("rst_busy",   32'(tb_if.busy),            32'd0);
        check("rst_ackg",   32'(tb_if.ack_grant),       32'd0);
        check("rst_credg",  32'(tb_if.credit_grant),    32'd0);
        check("rst_ready",  32'(tb_if.egress_in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single data byte 0x41
        base_r = n_rdy;
        tb_if.egress_in_data  = 8'h41;
        tb_if.egress_in_valid = 1'b1;
        wait_byte(8'h41, "d41", 1, g);
        check("d41_latency", 32'(g), 32'd1);
        check("d41_ready_cnt", 32'(n_rdy), 32'(base_r + 1));
        idle_check("d41");

        // Escaped data byte 0xFE -> FE, GAP, FE
        base_r = n_rdy;
        tb_if.egress_in_data  = 8'hfe;
        tb_if.egress_in_valid = 1'b1;
        wait_byte(8'hfe, "dfe0", 0, g);
        check("dfe0_latency", 32'(g), 32'd1);
        wait_byte(8'hfe, "dfe1", 0, g);
        check("dfe1_gap", 32'(g), 32'd1);
        check("dfe_ready_cnt", 32'(n_rdy), 32'(base_r + 1));
        idle_check("dfe");

        // Credit 0x1234 -> FE 92 34, value changed mid-message
        base_c = n_cred;
        tb_if.credit_value = 14'h1234;
        tb_if.credit_req   = 1'b1;
        wait_byte(8'hfe, "cr0", 0, g);
        tb_if.credit_value = 14'h3fff;
        wait_byte(8'h92, "cr1", 2, g);
        check("cr1_gap", 32'(g), 32'd1);
        wait_byte(8'h34, "cr2", 0, g);
        check("cr_grant_cnt", 32'(n_cred), 32'(base_c + 1));
        idle_check("cr");

        // Simultaneous ack, credit and data
        base_a = n_ack;
        base_c = n_cred;
        base_r = n_rdy;
        base_q = order_q.size();
        tb_if.ack_code        = 4'h3;
        tb_if.ack_req         = 1'b1;
        tb_if.credit_value    = 14'h0005;
        tb_if.credit_req      = 1'b1;
        tb_if.egress_in_data  = 8'h10;
        tb_if.egress_in_valid = 1'b1;
        wait_byte(8'hfe, "sa0", 0, g);
        wait_byte(8'hc3, "sa1", 0, g);
        wait_byte(8'hfe, "sc0", 0, g);
        check("sc0_between_msgs", 32'(g), 32'd1);
        wait_byte(8'h80, "sc1", 0, g);
        wait_byte(8'h05, "sc2", 0, g);
        wait_byte(8'h10, "sd0", 0, g);
        idle_check("sim");
        check("sim_ack_cnt",  32'(n_ack),  32'(base_a + 1));
        check("sim_cred_cnt", 32'(n_cred), 32'(base_c + 1));
        check("sim_rdy_cnt",  32'(n_rdy),  32'(base_r + 1));
        check("sim_order_len", 32'(order_q.size()), 32'(base_q + 3));
        if (order_q.size() >= base_q + 3) begin
            check("sim_order0", 32'(order_q[base_q]),     32'd1);
            check("sim_order1", 32'(order_q[base_q + 1]), 32'd2);
            check("sim_order2", 32'(order_q[base_q + 2]), 32'd3);
        end

        // Hold blocks pending data
        base_r = n_rdy;
        tb_if.hold            = 1'b1;
        tb_if.egress_in_data  = 8'h55;
        tb_if.egress_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_ready", 32'(tb_if.egress_in_ready), 32'd0);
            check("hold_en",    32'(tb_if.tx_enable),       32'd0);
        end
        @(posedge clk);
        #1;
        // Credit wins over pending data; hold raised mid-message
        tb_if.hold         = 1'b0;
        tb_if.credit_value = 14'h0abc;
        tb_if.credit_req   = 1'b1;
        wait_byte(8'hfe, "hc0", 0, g);
        tb_if.hold = 1'b1;
        wait_byte(8'h8a, "hc1", 0, g);
        wait_byte(8'hbc, "hc2", 0, g);
        check("hc_no_data_yet", 32'(n_rdy), 32'(base_r));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold2_ready", 32'(tb_if.egress_in_ready), 32'd0);
            check("hold2_en",    32'(tb_if.tx_enable),       32'd0);
            check("hold2_busy",  32'(tb_if.busy),            32'd0);
        end
        @(posedge clk);
        #1;
        tb_if.hold = 1'b0;
        wait_byte(8'h55, "hd0", 0, g);
        check("hd0_latency", 32'(g), 32'd1);
        check("hd0_ready_cnt", 32'(n_rdy), 32'(base_r + 1));
        idle_check("hd");

        // Reset during second byte of a credit message
        tb_if.credit_value = 14'h0123;
        tb_if.credit_req   = 1'b1;
        wait_byte(8'hfe, "rc0", 0, g);
        @(negedge clk);
        check("rc_gap_en", 32'(tb_if.tx_enable), 32'd0);
        @(negedge clk);
        check("rc1_en",   32'(tb_if.tx_enable), 32'd1);
        check("rc1_data", 32'(tb_if.tx_data),   32'h81);
        rst           = 1'b1;
        tb_if.tx_done = 1'b1;
        #1;
        check("rst_mid_en",   32'(tb_if.tx_enable), 32'd0);
        check("rst_mid_busy", 32'(tb_if.busy),      32'd0);
        check("rst_mid_data", 32'(tb_if.tx_data),   32'h00);
        @(posedge clk);
        #1;
        check("rst_hold_en", 32'(tb_if.tx_enable), 32'd0);
        rst           = 1'b0;
        tb_if.tx_done = 1'b0;
        tb_if.ack_code = 4'ha;
        tb_if.ack_req  = 1'b1;
        wait_byte(8'hfe, "ra0", 0, g);
        check("ra0_latency", 32'(g), 32'd1);
        wait_byte(8'hca, "ra1", 0, g);
        idle_check("ra");

        check("multi_grant", 32'(n_multi),  32'd0);
        check("ready_wo_valid", 32'(n_badrdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
